// File: rtl/pc_redirect_if.sv
// Redirect-controller bus: exec/trap PC-write requests in, fetch handshake and
// PC register write port out.
interface pc_redirect_if #(
   parameter int unsigned CNT_W = 32
);
   logic             ex_valid;
   logic             br_w_op;
   logic [31:0]      br_w_val;
   logic             jmp_w_op;
   logic [31:0]      jmp_w_val;
   logic             trap_w_op;
   logic [31:0]      trap_w_val;
   logic             redir_ready;
   logic             redir_valid;
   logic [31:0]      redir_pc;
   logic             flush;
   logic             stall;
   logic             reg_pc_w_op;
   logic [31:0]      reg_pc_w_val;
   logic             misalign_exc;
   logic [31:0]      misalign_addr;
   logic [CNT_W-1:0] redir_cnt;

   modport master (
      output ex_valid, br_w_op, br_w_val, jmp_w_op, jmp_w_val,
             trap_w_op, trap_w_val, redir_ready,
      input  redir_valid, redir_pc, flush, stall, reg_pc_w_op, reg_pc_w_val,
             misalign_exc, misalign_addr, redir_cnt
   );

   modport slave (
      input  ex_valid, br_w_op, br_w_val, jmp_w_op, jmp_w_val,
             trap_w_op, trap_w_val, redir_ready,
      output redir_valid, redir_pc, flush, stall, reg_pc_w_op, reg_pc_w_val,
             misalign_exc, misalign_addr, redir_cnt
   );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Arbitrates trap/jump/branch PC writes, flushes IF/ID for FLUSH_CYCLES cycles,
// then offers the target to fetch and writes the PC register on acceptance.
module pc_redirect_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input logic          clk,
   input logic          rst,
   pc_redirect_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t           state, state_nxt;
   logic [3:0]       flush_cnt, flush_cnt_nxt;
   logic [31:0]      target, target_nxt;
   logic [CNT_W-1:0] redir_cnt;
   logic             mis_exc, mis_exc_nxt;
   logic [31:0]      mis_addr, mis_addr_nxt;
   logic             accept;
   logic [31:0]      trap_tgt;

   assign trap_tgt = bus.trap_w_val & ~32'h3;

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      target_nxt    = target;
      mis_exc_nxt   = 1'b0;
      mis_addr_nxt  = 32'h0;
      accept        = 1'b0;
      case (state)
         IDLE: begin
            if (bus.trap_w_op) begin
               target_nxt    = trap_tgt;
               flush_cnt_nxt = FLUSH_LOAD;
               state_nxt     = FLUSH;
            end else if (bus.ex_valid && bus.jmp_w_op) begin
               if (bus.jmp_w_val[1:0] != 2'b00) begin
                  mis_exc_nxt  = 1'b1;
                  mis_addr_nxt = bus.jmp_w_val;
               end else begin
                  target_nxt    = bus.jmp_w_val;
                  flush_cnt_nxt = FLUSH_LOAD;
                  state_nxt     = FLUSH;
               end
            end else if (bus.ex_valid && bus.br_w_op) begin
               if (bus.br_w_val[1:0] != 2'b00) begin
                  mis_exc_nxt  = 1'b1;
                  mis_addr_nxt = bus.br_w_val;
               end else begin
                  target_nxt    = bus.br_w_val;
                  flush_cnt_nxt = FLUSH_LOAD;
                  state_nxt     = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (bus.trap_w_op) begin
               target_nxt    = trap_tgt;
               flush_cnt_nxt = FLUSH_LOAD;
            end else if (flush_cnt == 4'd0) begin
               state_nxt = REDIRECT;
            end else begin
               flush_cnt_nxt = flush_cnt - 4'd1;
            end
         end
         REDIRECT: begin
            // An accepted redirect always completes; a trap must persist to be seen from IDLE.
            if (bus.redir_ready) begin
               accept    = 1'b1;
               state_nxt = IDLE;
            end else if (bus.trap_w_op) begin
               target_nxt    = trap_tgt;
               flush_cnt_nxt = FLUSH_LOAD;
               state_nxt     = FLUSH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset discards any pending target.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         flush_cnt <= 4'd0;
         target    <= 32'h0;
         redir_cnt <= '0;
         mis_exc   <= 1'b0;
         mis_addr  <= 32'h0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
         target    <= target_nxt;
         mis_exc   <= mis_exc_nxt;
         mis_addr  <= mis_addr_nxt;
         if (accept) redir_cnt <= redir_cnt + CNT_W'(1);
      end
   end

   assign bus.flush         = (state == FLUSH);
   assign bus.stall         = (state != IDLE);
   assign bus.redir_valid   = (state == REDIRECT);
   assign bus.redir_pc      = (state == REDIRECT) ? target : 32'h0;
   assign bus.reg_pc_w_op   = accept;
   assign bus.reg_pc_w_val  = accept ? target : 32'h0;
   assign bus.misalign_exc  = mis_exc;
   assign bus.misalign_addr = mis_addr;
   assign bus.redir_cnt     = redir_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl; expected PC writes go through a scoreboard queue.
module tb_pc_redirect_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [31:0] sb[$];

   pc_redirect_if #(.CNT_W(32)) bus ();

   pc_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ctl(input string tag, input logic f, input logic v, input logic s);
      check({tag, "_flush"}, 32'(bus.flush), 32'(f));
      check({tag, "_valid"}, 32'(bus.redir_valid), 32'(v));
      check({tag, "_stall"}, 32'(bus.stall), 32'(s));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic clear_req();
      bus.ex_valid  = 1'b0;
      bus.br_w_op   = 1'b0;
      bus.jmp_w_op  = 1'b0;
      bus.trap_w_op = 1'b0;
   endtask

   // Scoreboard side: every PC write must match the oldest expected target.
   always @(negedge clk) begin
      if (bus.reg_pc_w_op === 1'b1) begin
         check("pc_write_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) check("pc_write_val", bus.reg_pc_w_val, sb.pop_front());
      end else begin
         check("pc_val_idle", bus.reg_pc_w_val, 32'h0);
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      clear_req();
      bus.br_w_val    = 32'h0;
      bus.jmp_w_val   = 32'h0;
      bus.trap_w_val  = 32'h0;
      bus.redir_ready = 1'b0;

      next_cycle();
      next_cycle();
      sample();
      ctl("reset", 1'b0, 1'b0, 1'b0);
      check("reset_cnt", bus.redir_cnt, 32'd0);
      check("reset_wop", 32'(bus.reg_pc_w_op), 32'd0);
      check("reset_mis", 32'(bus.misalign_exc), 32'd0);
      next_cycle();
      rst = 1'b0;

      // 1: branch to 0x100, ready high
      next_cycle();
      bus.ex_valid = 1'b1; bus.br_w_op = 1'b1; bus.br_w_val = 32'h100; bus.redir_ready = 1'b1;
      sb.push_back(32'h100);
      sample(); ctl("t1_n0", 1'b0, 1'b0, 1'b0);
      next_cycle(); clear_req();
      sample(); ctl("t1_n1", 1'b1, 1'b0, 1'b1);
      next_cycle();
      sample(); ctl("t1_n2", 1'b1, 1'b0, 1'b1);
      next_cycle();
      sample(); ctl("t1_n3", 1'b0, 1'b1, 1'b1);
      check("t1_pc", bus.redir_pc, 32'h100);
      check("t1_wop", 32'(bus.reg_pc_w_op), 32'd1);
      next_cycle();
      sample(); ctl("t1_n4", 1'b0, 1'b0, 1'b0);
      check("t1_cnt", bus.redir_cnt, 32'd1);

      // 2: branch, jump and trap together; trap wins with low bits cleared
      next_cycle();
      bus.ex_valid = 1'b1;
      bus.br_w_op = 1'b1;   bus.br_w_val = 32'h200;
      bus.jmp_w_op = 1'b1;  bus.jmp_w_val = 32'h300;
      bus.trap_w_op = 1'b1; bus.trap_w_val = 32'h403;
      sb.push_back(32'h400);
      next_cycle(); clear_req();
      sample(); ctl("t2_n1", 1'b1, 1'b0, 1'b1);
      next_cycle();
      sample(); ctl("t2_n2", 1'b1, 1'b0, 1'b1);
      next_cycle();
      sample(); ctl("t2_n3", 1'b0, 1'b1, 1'b1);
      check("t2_pc", bus.redir_pc, 32'h400);
      next_cycle();
      sample(); check("t2_cnt", bus.redir_cnt, 32'd2);
      check("t2_mis", 32'(bus.misalign_exc), 32'd0);

      // 3: misaligned jump
      next_cycle();
      bus.ex_valid = 1'b1; bus.jmp_w_op = 1'b1; bus.jmp_w_val = 32'h102;
      next_cycle(); clear_req();
      sample(); ctl("t3_n1", 1'b0, 1'b0, 1'b0);
      check("t3_exc", 32'(bus.misalign_exc), 32'd1);
      check("t3_addr", bus.misalign_addr, 32'h102);
      next_cycle();
      sample(); ctl("t3_n2", 1'b0, 1'b0, 1'b0);
      check("t3_exc_pulse", 32'(bus.misalign_exc), 32'd0);
      check("t3_cnt", bus.redir_cnt, 32'd2);

      // 4: ready held low 5 cycles in REDIRECT
      next_cycle();
      bus.redir_ready = 1'b0;
      bus.ex_valid = 1'b1; bus.br_w_op = 1'b1; bus.br_w_val = 32'h500;
      sb.push_back(32'h500);
      next_cycle(); clear_req();
      sample(); ctl("t4_f1", 1'b1, 1'b0, 1'b1);
      next_cycle();
      sample(); ctl("t4_f2", 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         sample(); ctl("t4_wait", 1'b0, 1'b1, 1'b1);
         check("t4_wait_pc", bus.redir_pc, 32'h500);
         check("t4_wait_wop", 32'(bus.reg_pc_w_op), 32'd0);
      end
      next_cycle();
      bus.redir_ready = 1'b1;
      sample(); check("t4_accept_wop", 32'(bus.reg_pc_w_op), 32'd1);
      check("t4_accept_pc", bus.redir_pc, 32'h500);
      next_cycle();
      sample(); ctl("t4_done", 1'b0, 1'b0, 1'b0);
      check("t4_cnt", bus.redir_cnt, 32'd3);

      // 5: trap preempts in second flush cycle
      next_cycle();
      bus.ex_valid = 1'b1; bus.br_w_op = 1'b1; bus.br_w_val = 32'h600;
      sb.push_back(32'h700);
      next_cycle(); clear_req();
      sample(); ctl("t5_f1", 1'b1, 1'b0, 1'b1);
      next_cycle();
      bus.trap_w_op = 1'b1; bus.trap_w_val = 32'h700;
      sample(); ctl("t5_f2", 1'b1, 1'b0, 1'b1);
      next_cycle(); clear_req();
      sample(); ctl("t5_f3", 1'b1, 1'b0, 1'b1);
      next_cycle();
      sample(); ctl("t5_f4", 1'b1, 1'b0, 1'b1);
      next_cycle();
      sample(); ctl("t5_redir", 1'b0, 1'b1, 1'b1);
      check("t5_pc", bus.redir_pc, 32'h700);
      next_cycle();
      sample(); check("t5_cnt", bus.redir_cnt, 32'd4);

      // 6: reset while in REDIRECT with ready low, then a gated-off branch
      next_cycle();
      bus.redir_ready = 1'b0;
      bus.ex_valid = 1'b1; bus.br_w_op = 1'b1; bus.br_w_val = 32'h800;
      next_cycle(); clear_req();
      next_cycle();
      next_cycle();
      sample(); ctl("t6_redir", 1'b0, 1'b1, 1'b1);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      bus.ex_valid = 1'b0; bus.br_w_op = 1'b1; bus.br_w_val = 32'h900;
      sample(); ctl("t6_rst", 1'b0, 1'b0, 1'b0);
      check("t6_cnt", bus.redir_cnt, 32'd0);
      check("t6_pc", bus.redir_pc, 32'h0);
      check("t6_wop", 32'(bus.reg_pc_w_op), 32'd0);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         sample(); ctl("t6_ignored", 1'b0, 1'b0, 1'b0);
         check("t6_ignored_mis", 32'(bus.misalign_exc), 32'd0);
      end
      next_cycle(); clear_req();

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
